// File: rtl/dm_pkg.sv
// Debug-module type slice used by the DMI bus bridge.
// Carries the DMI request/response channel types, the DTM op/response codes
// and the bus-address bit that selects the bridge control word.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  // Bus address bit that redirects an access to the bridge control word.
  localparam int unsigned DmiBridgeCtrlBit = 9;

endpackage

// File: rtl/dmi_bus_bridge.sv
// Memory-mapped system-bus initiator for the Debug Module Interface.
// Each granted bus transfer becomes one DMI request (re-issued on DTM_BUSY up
// to MaxRetries times) and completes with a single r_valid_o beat.
// BusWidth must be 32 or 64; with 64, addr_i[2] selects the active 32-bit lane.
// Optional macro DMI_BRIDGE_TIMEOUT_EN: abort a response wait after
// TimeoutCycles cycles, pulsing dmi_rst_no and reporting an error.
module dmi_bus_bridge
  import dm::*;
#(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned MaxRetries    = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [BusWidth-1:0]   addr_i,
  input  logic [BusWidth/8-1:0] be_i,
  input  logic [BusWidth-1:0]   wdata_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [BusWidth-1:0]   r_rdata_o,
  output logic                  r_err_o,
  output logic                  dmi_rst_no,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output dmi_req_t              dmi_req_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  dmi_resp_t             dmi_resp_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  state_e            state_q, state_d;
  dmi_req_t          req_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              sticky_q, sticky_d;
  logic              busy_q, busy_d;
  logic              done_err;
  logic [31:0]       done_data;
  logic              rst_pulse;
  logic              tmo_hit;
  logic [3:0]        be_lane;
  logic [31:0]       wdata_lane;
  logic              ctrl_sel;
  logic              unused_addr;

  assign ctrl_sel    = addr_i[DmiBridgeCtrlBit];
  assign unused_addr = ^{addr_i[BusWidth-1:10], addr_i[1:0]};

  if (BusWidth == 64) begin : g_lane64
    assign be_lane    = addr_i[2] ? be_i[7:4] : be_i[3:0];
    assign wdata_lane = addr_i[2] ? wdata_i[63:32] : wdata_i[31:0];
  end else begin : g_lane32
    assign be_lane    = be_i[3:0];
    assign wdata_lane = wdata_i[31:0];
  end

`ifdef DMI_BRIDGE_TIMEOUT_EN
  localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic [TmoW-1:0] tmo_q;

  assign tmo_hit = (tmo_q == TmoW'(TimeoutCycles - 1));

  // Count cycles spent waiting for a response; cleared everywhere else.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (state_q == S_WAIT && !dmi_resp_valid_i) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state, handshake and completion decisions.
  always_comb begin
    state_d          = state_q;
    req_d            = dmi_req_o;
    retry_d          = retry_q;
    sticky_d         = sticky_q;
    busy_d           = busy_q;
    done_err         = 1'b0;
    done_data        = '0;
    rst_pulse        = 1'b0;
    gnt_o            = 1'b0;
    dmi_resp_ready_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          if (be_lane != 4'hF) begin
            state_d  = S_DONE;
            done_err = 1'b1;
          end else if (ctrl_sel) begin
            state_d = S_DONE;
            if (we_i) begin
              if (wdata_lane[0]) begin
                rst_pulse = 1'b1;
                sticky_d  = 1'b0;
              end
            end else begin
              done_data = {30'b0, busy_q, sticky_q};
            end
          end else begin
            state_d    = S_REQ;
            req_d.addr = addr_i[8:2];
            req_d.op   = we_i ? DTM_WRITE : DTM_READ;
            req_d.data = we_i ? wdata_lane : '0;
          end
        end
      end
      S_REQ: begin
        if (dmi_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          if (dmi_resp_i.resp == DTM_SUCCESS) begin
            state_d   = S_DONE;
            done_data = (dmi_req_o.op == DTM_WRITE) ? '0 : dmi_resp_i.data;
          end else if (dmi_resp_i.resp == DTM_BUSY) begin
            busy_d = 1'b1;
            if (retry_q < RetryW'(MaxRetries)) begin
              retry_d = retry_q + 1'b1;
              state_d = S_REQ;
            end else begin
              done_err = 1'b1;
              sticky_d = 1'b1;
              state_d  = S_DONE;
            end
          end else begin
            done_err = 1'b1;
            sticky_d = 1'b1;
            state_d  = S_DONE;
          end
        end else if (tmo_hit) begin
          done_err  = 1'b1;
          sticky_d  = 1'b1;
          rst_pulse = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        retry_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, status bits and registered outputs; outputs are derived from the
  // next state so they line up with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      dmi_req_o       <= '0;
      retry_q         <= '0;
      sticky_q        <= 1'b0;
      busy_q          <= 1'b0;
      dmi_req_valid_o <= 1'b0;
      r_valid_o       <= 1'b0;
      r_err_o         <= 1'b0;
      r_rdata_o       <= '0;
      dmi_rst_no      <= 1'b1;
    end else begin
      state_q         <= state_d;
      dmi_req_o       <= req_d;
      retry_q         <= retry_d;
      sticky_q        <= sticky_d;
      busy_q          <= busy_d;
      dmi_req_valid_o <= (state_d == S_REQ);
      r_valid_o       <= (state_d == S_DONE);
      r_err_o         <= done_err;
      r_rdata_o       <= {(BusWidth / 32){done_data}};
      dmi_rst_no      <= ~rst_pulse;
    end
  end

endmodule

// File: doc/dmi_bus_bridge.md
# dmi_bus_bridge

Memory-mapped initiator for the Debug Module Interface. A system-bus master (boot CPU, test controller, or secure-debug agent) issues plain req/we/addr/be/wdata transfers, and the bridge turns each one into exactly one DMI request. It waits for the DMI response and returns it as a read-data/valid/error beat. It sits where the JTAG DTM would, and connects directly to the debug module's `dmi_req_*`, `dmi_resp_*` and `dmi_rst_ni` ports.

## Interface
Parameters:
- `BusWidth`, 32: bus data/address width; only 32 and 64 are legal.
- `MaxRetries`, 8: number of re-issues after a DTM_BUSY response before the transfer errors.
- `TimeoutCycles`, 1024: response wait limit; used only with `DMI_BRIDGE_TIMEOUT_EN`.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in 1: bus request.
- `we_i` in 1: write enable.
- `addr_i` in BusWidth: byte address.
- `be_i` in BusWidth/8: byte enables.
- `wdata_i` in BusWidth: write data.
- `gnt_o` out 1: request accepted.
- `r_valid_o` out 1: response beat.
- `r_rdata_o` out BusWidth: read data.
- `r_err_o` out 1: transfer failed; qualified by `r_valid_o`.
- `dmi_rst_no` out 1: synchronous DMI clear pulse, active-low.
- `dmi_req_valid_o` out 1, `dmi_req_ready_i` in 1, `dmi_req_o` out `dm::dmi_req_t`: DMI request channel.
- `dmi_resp_valid_i` in 1, `dmi_resp_ready_o` out 1, `dmi_resp_i` in `dm::dmi_resp_t`: DMI response channel.

## Operation
Address decode:
- `addr_i[8:2]` gives the DMI address.
- `addr_i[9]=1` selects the bridge control word instead of the DMI.
- Higher address bits are ignored.

Data lanes and byte enables:
- With BusWidth=64, `addr_i[2]` selects the 32-bit lane.
- Read data is replicated on both lanes.
- Every enabled transfer must have all four byte enables set on the selected lane. Anything else completes with `r_err_o=1` and no DMI traffic.

Control word:
- Write with bit0=1: drives `dmi_rst_no` low for exactly one cycle and clears `sticky_err`.
- Read: returns `{30'b0, busy_seen, sticky_err}`.
- `sticky_err` sets on any errored DMI transfer. `busy_seen` sets on any DTM_BUSY response.

States:
- **IDLE**:
  - `gnt_o = req_i`.
  - On grant, latch the DMI address, op (DTM_WRITE if `we_i`, else DTM_READ) and data.
  - Next state is REQ; byte-enable violations and control-word accesses go to DONE instead.
- **REQ**: `dmi_req_valid_o=1`. On `dmi_req_ready_i`, go to WAIT.
- **WAIT**: `dmi_resp_ready_o=1`. On `dmi_resp_valid_i`:
  - resp=DTM_SUCCESS: capture data, go to DONE.
  - resp=DTM_ERR: set the error flag, go to DONE.
  - resp=DTM_BUSY: if the retry count is below `MaxRetries`, increment it and return to REQ; otherwise set the error flag and go to DONE.
- **DONE**: `r_valid_o=1` for one cycle, then return to IDLE and clear the retry count.

Other rules:
- Write transfers return `r_rdata_o=0`.
- Only one transfer is outstanding at a time; `gnt_o=0` in every state except IDLE.
- `dmi_req_o` holds stable while `dmi_req_valid_o=1`.

## Timing
- Reset values: all outputs 0, except `dmi_rst_no=1` and `dmi_req_o='0` (op DTM_NOP).
  - Reset clears the state to IDLE and clears all counters and sticky bits.
  - Reset mid-transfer abandons the transfer. No `r_valid_o` is issued for it.
- `dmi_req_valid_o`, `r_valid_o`, `r_rdata_o`, `r_err_o` and `dmi_rst_no` are registered.
- `gnt_o`, `dmi_resp_ready_o` and the handshake decisions are combinational from state and inputs.
- Minimum latency with ready and response both immediate:
  - grant at cycle 0;
  - request valid at cycle 1;
  - response accepted at cycle 2;
  - `r_valid_o` at cycle 3.
- Control-word and byte-enable-error transfers: grant at cycle 0, `r_valid_o` at cycle 1.
- A BUSY retry adds 2 cycles per retry.
- A response arriving in the same cycle as a control-word write is impossible, because the bridge is not in WAIT during that access.

## Configuration
`DMI_BRIDGE_TIMEOUT_EN`:
- **Defined:** a counter runs in WAIT. When it reaches `TimeoutCycles-1` without a response:
  - pulse `dmi_rst_no` low for one cycle;
  - set `r_err_o` and `sticky_err`;
  - go to DONE.
- **Undefined:** no counter; WAIT waits indefinitely.

## Structure
- Use `dm::dmi_req_t`, `dm::dmi_resp_t` and `dm::dtm_op_e` from the `dm` package. Add `dm::DmiBridgeCtrlBit = 9` there.
- Everything else is local, in a single module with no sub-modules.

## Test plan
- **Read:** read of 0x44 (dmstatus), DMI responds SUCCESS with data 0x00400382. Required: DMI addr 0x11, op READ; `r_rdata_o=0x00400382`, `r_err_o=0`; `r_valid_o` 3 cycles after grant.
- **Write with stalls:** write 0x8000_0001 to 0x40 (dmcontrol) while `dmi_req_ready_i` is held low for 4 cycles. Required: request data and addr 0x10 held stable throughout; then `r_valid_o` with `r_err_o=0`.
- **BUSY retries:** DMI returns BUSY on 3 responses, then SUCCESS. Required: 4 requests observed, no error, `busy_seen` reads 1. With `MaxRetries=2`, the same stimulus gives `r_err_o=1` after 3 requests.
- **Partial write:** write with `be_i=4'b0011`. Required: no DMI request; `r_err_o=1` one cycle after grant.
- **Control word:** write 1 to 0x200 after an errored transfer. Required: `dmi_rst_no` low for exactly one cycle; a subsequent read of 0x200 returns bit0=0.
- **Timeout (macro defined), with reset:** no response for `TimeoutCycles` cycles. Required: `dmi_rst_no` pulse, then `r_err_o=1`. A separate run asserts `rst_ni` during WAIT. Required: no `r_valid_o`, and `gnt_o` is available 1 cycle after reset release.
